// File: rtl/jb_relay_pkg.sv
// rtl/jb_relay_pkg.sv - shared types and defaults for the joybus relay
// Purpose: per-channel state encoding, default timing constants and the
//          counter-width helper used by jb_relay and jb_relay_ch.
package jb_relay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CONS_TX   = 2'd1,
    ST_CTLR_WAIT = 2'd2,
    ST_CTLR_TX   = 2'd3
  } jb_state_e;

  // 4 us of idle line at 50 MHz ends a transmit phase
  localparam int DEF_IDLE_CYC     = 200;
  localparam int DEF_RESP_TIMEOUT = 5000;

  localparam logic [7:0] EDGE_MAX = 8'd255;

  // One spare bit above what the larger limit needs, so the saturation
  // ceiling always sits above both compare points.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/jb_relay_ch.sv
// rtl/jb_relay_ch.sv - one console/controller joybus relay channel
// Purpose: synchronizes both line levels, tracks the command/response phases
//          and drives the opposite side's open-drain enable.
// Ports:   i_clk, i_rst (async, active high)
//          i_cons_rx, i_ctlr_rx  raw line levels
//          i_mute                suppress response forwarding (sampled at response start)
//          i_ovr_req, i_ovr_low  response override (only with JB_RELAY_OVERRIDE_EN)
//          o_cons_oe, o_ctlr_oe  registered pull-low enables
//          o_busy, o_done, o_timeout, o_cmd_edges status
module jb_relay_ch
  import jb_relay_pkg::*;
#(
  parameter int IDLE_CYC     = DEF_IDLE_CYC,
  parameter int RESP_TIMEOUT = DEF_RESP_TIMEOUT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cons_rx,
  input  logic       i_ctlr_rx,
  input  logic       i_mute,
`ifdef JB_RELAY_OVERRIDE_EN
  input  logic       i_ovr_req,
  input  logic       i_ovr_low,
`endif
  output logic       o_cons_oe,
  output logic       o_ctlr_oe,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_timeout,
  output logic [7:0] o_cmd_edges
);

  localparam int            CW       = cnt_width(IDLE_CYC, RESP_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] IDLE_LIM = CW'(IDLE_CYC);
  localparam logic [CW-1:0] RESP_LIM = CW'(RESP_TIMEOUT);

  jb_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [7:0]    r_edges, w_edges_nxt;
  logic          r_cons_s1, r_cons_s2, r_cons_s3;
  logic          r_ctlr_s1, r_ctlr_s2;
  logic          r_armed;
  logic          r_mute, w_mute_nxt;
  logic          r_cons_oe, w_cons_oe_nxt;
  logic          r_ctlr_oe, w_ctlr_oe_nxt;
  logic          r_done, w_done_nxt;
  logic          r_timeout, w_to_nxt;
  logic          w_cons_fall;
  logic          w_rsp_low;
  logic          w_fwd_entry;
  logic          w_fwd;

  assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
  // r_cons_s3 only feeds edge detection, so it adds nothing to drive latency
  assign w_cons_fall = r_cons_s3 & ~r_cons_s2;

`ifdef JB_RELAY_OVERRIDE_EN
  logic r_ovr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovr <= 1'b0;
    end else if (r_state == ST_CONS_TX && w_state_nxt == ST_CTLR_WAIT) begin
      r_ovr <= i_ovr_req;
    end
  end

  // An overridden response is sourced from i_ovr_low and is never muted
  assign w_rsp_low   = r_ovr ? i_ovr_low : ~r_ctlr_s2;
  assign w_fwd_entry = r_ovr | ~i_mute;
  assign w_fwd       = r_ovr | ~r_mute;
`else
  assign w_rsp_low   = ~r_ctlr_s2;
  assign w_fwd_entry = ~i_mute;
  assign w_fwd       = ~r_mute;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // Syncs reset low so a line held low through reset never looks like
      // a fresh falling edge until it has been seen high (r_armed).
      r_cons_s1 <= 1'b0;
      r_cons_s2 <= 1'b0;
      r_cons_s3 <= 1'b0;
      r_ctlr_s1 <= 1'b0;
      r_ctlr_s2 <= 1'b0;
      r_armed   <= 1'b0;
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_edges   <= '0;
      r_mute    <= 1'b0;
      r_cons_oe <= 1'b0;
      r_ctlr_oe <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_cons_s1 <= i_cons_rx;
      r_cons_s2 <= r_cons_s1;
      r_cons_s3 <= r_cons_s2;
      r_ctlr_s1 <= i_ctlr_rx;
      r_ctlr_s2 <= r_ctlr_s1;
      r_armed   <= r_armed | r_cons_s2;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_edges   <= w_edges_nxt;
      r_mute    <= w_mute_nxt;
      r_cons_oe <= w_cons_oe_nxt;
      r_ctlr_oe <= w_ctlr_oe_nxt;
      r_done    <= w_done_nxt;
      r_timeout <= w_to_nxt;
    end
  end

  // The oe registers load from next-state logic so the first drive lands
  // on the same edge as the state change: pin -> s1 -> s2 -> oe.
  // Each phase only looks at the side it is not driving (no self-echo).
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_edges_nxt   = r_edges;
    w_mute_nxt    = r_mute;
    w_cons_oe_nxt = 1'b0;
    w_ctlr_oe_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    w_to_nxt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && !r_cons_s2) begin
          w_state_nxt   = ST_CONS_TX;
          w_cnt_nxt     = '0;
          w_edges_nxt   = 8'd1;
          w_ctlr_oe_nxt = 1'b1;
        end
      end
      ST_CONS_TX: begin
        w_ctlr_oe_nxt = ~r_cons_s2;
        w_cnt_nxt     = r_cons_s2 ? w_cnt_inc : '0;
        if (w_cons_fall && r_edges != EDGE_MAX) begin
          w_edges_nxt = r_edges + 8'd1;
        end
        if (r_cons_s2 && w_cnt_inc == IDLE_LIM) begin
          w_state_nxt = ST_CTLR_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_CTLR_WAIT: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_rsp_low) begin
          w_state_nxt   = ST_CTLR_TX;
          w_cnt_nxt     = '0;
          w_mute_nxt    = i_mute;
          w_cons_oe_nxt = w_fwd_entry;
        end else if (w_cnt_inc == RESP_LIM) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_to_nxt    = 1'b1;
        end
      end
      ST_CTLR_TX: begin
        w_cons_oe_nxt = w_rsp_low & w_fwd;
        w_cnt_nxt     = w_rsp_low ? '0 : w_cnt_inc;
        if (!w_rsp_low && w_cnt_inc == IDLE_LIM) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_cons_oe   = r_cons_oe;
  assign o_ctlr_oe   = r_ctlr_oe;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = r_done;
  assign o_timeout   = r_timeout;
  assign o_cmd_edges = r_edges;

endmodule

// File: rtl/jb_relay.sv
// rtl/jb_relay.sv - multi-channel joybus console/controller relay
// Purpose: NUM_CH independent relay channels (jb_relay_ch) side by side.
// Ports:   i_clk, i_rst (async, active high)
//          i_cons_rx, i_ctlr_rx, i_mute       [NUM_CH] inputs
//          i_ovr_req, i_ovr_low               [NUM_CH] only with JB_RELAY_OVERRIDE_EN
//          o_cons_oe, o_ctlr_oe, o_busy, o_done, o_timeout [NUM_CH]
//          o_cmd_edges [8*NUM_CH] channel n in bits [8n+7:8n]
// Macro:   JB_RELAY_OVERRIDE_EN enables the response override ports.
module jb_relay
  import jb_relay_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int IDLE_CYC     = DEF_IDLE_CYC,
  parameter int RESP_TIMEOUT = DEF_RESP_TIMEOUT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_CH-1:0]     i_cons_rx,
  input  logic [NUM_CH-1:0]     i_ctlr_rx,
  input  logic [NUM_CH-1:0]     i_mute,
`ifdef JB_RELAY_OVERRIDE_EN
  input  logic [NUM_CH-1:0]     i_ovr_req,
  input  logic [NUM_CH-1:0]     i_ovr_low,
`endif
  output logic [NUM_CH-1:0]     o_cons_oe,
  output logic [NUM_CH-1:0]     o_ctlr_oe,
  output logic [NUM_CH-1:0]     o_busy,
  output logic [NUM_CH-1:0]     o_done,
  output logic [NUM_CH-1:0]     o_timeout,
  output logic [8*NUM_CH-1:0]   o_cmd_edges
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    jb_relay_ch #(
      .IDLE_CYC     (IDLE_CYC),
      .RESP_TIMEOUT (RESP_TIMEOUT)
    ) u_ch (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_cons_rx   (i_cons_rx[g]),
      .i_ctlr_rx   (i_ctlr_rx[g]),
      .i_mute      (i_mute[g]),
`ifdef JB_RELAY_OVERRIDE_EN
      .i_ovr_req   (i_ovr_req[g]),
      .i_ovr_low   (i_ovr_low[g]),
`endif
      .o_cons_oe   (o_cons_oe[g]),
      .o_ctlr_oe   (o_ctlr_oe[g]),
      .o_busy      (o_busy[g]),
      .o_done      (o_done[g]),
      .o_timeout   (o_timeout[g]),
      .o_cmd_edges (o_cmd_edges[8*g +: 8])
    );
  end

endmodule

// File: tb/tb_jb_relay.sv
// tb/tb_jb_relay.sv - directed self-checking bench for jb_relay
module tb_jb_relay;

  localparam int NCH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [3:0]  i_cons_rx, i_ctlr_rx, i_mute;
  logic [3:0]  o_cons_oe, o_ctlr_oe, o_busy, o_done, o_timeout;
  logic [31:0] o_cmd_edges;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mirr_err = 0;
  int both_err = 0;
  int last_rise;
  int cons_seen [NCH];
  int ctlr_seen [NCH];
  int done_cnt  [NCH];
  int to_cnt    [NCH];
  logic [3:0] cons_d1, cons_d2, cons_d3;
  logic [3:0] ctlr_d1, ctlr_d2, ctlr_d3;
  logic [3:0] mon_ctlr, mon_cons, mute_exp;

  jb_relay dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cons_rx   (i_cons_rx),
    .i_ctlr_rx   (i_ctlr_rx),
    .i_mute      (i_mute),
    .o_cons_oe   (o_cons_oe),
    .o_ctlr_oe   (o_ctlr_oe),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_timeout   (o_timeout),
    .o_cmd_edges (o_cmd_edges)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge. A pin value
  // applied after edge e must show on the opposite oe after edge e+3.
  task automatic step();
    @(posedge i_clk);
    #1;
    cyc++;
    cons_d3 = cons_d2; cons_d2 = cons_d1; cons_d1 = i_cons_rx;
    ctlr_d3 = ctlr_d2; ctlr_d2 = ctlr_d1; ctlr_d1 = i_ctlr_rx;
    for (int c = 0; c < NCH; c++) begin
      if (mon_ctlr[c] && (o_ctlr_oe[c] !== ~cons_d3[c])) mirr_err++;
      if (mon_cons[c] && (o_cons_oe[c] !== (~ctlr_d3[c] & ~mute_exp[c]))) mirr_err++;
      if (o_cons_oe[c]) cons_seen[c]++;
      if (o_ctlr_oe[c]) ctlr_seen[c]++;
      if (o_done[c])    done_cnt[c]++;
      if (o_timeout[c]) to_cnt[c]++;
    end
    if ((o_cons_oe & o_ctlr_oe) != 4'd0) both_err++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    i_rst = 1'b1;
    i_cons_rx = 4'hF; i_ctlr_rx = 4'hF; i_mute = 4'h0;
    cons_d1 = 4'hF; cons_d2 = 4'hF; cons_d3 = 4'hF;
    ctlr_d1 = 4'hF; ctlr_d2 = 4'hF; ctlr_d3 = 4'hF;
    mon_ctlr = 4'hF; mon_cons = 4'hF; mute_exp = 4'h0;
    for (int c = 0; c < NCH; c++) begin
      cons_seen[c] = 0; ctlr_seen[c] = 0; done_cnt[c] = 0; to_cnt[c] = 0;
    end
    step(); step();
    chk("rst_cons_oe", {28'd0, o_cons_oe}, 32'd0);
    chk("rst_ctlr_oe", {28'd0, o_ctlr_oe}, 32'd0);
    chk("rst_busy",    {28'd0, o_busy},    32'd0);
    chk("rst_done",    {28'd0, o_done},    32'd0);
    chk("rst_timeout", {28'd0, o_timeout}, 32'd0);
    chk("rst_edges",   o_cmd_edges,        32'd0);
    i_rst = 1'b0;
    repeat (5) step();

    // ch0 command: 9 low pulses (4 low / 4 high)
    for (int p = 0; p < 9; p++) begin
      i_cons_rx[0] = 1'b0; repeat (4) step();
      i_cons_rx[0] = 1'b1; last_rise = cyc; repeat (4) step();
    end
    run_to(last_rise + 202);
    chk("cmd_edges_ch0",  {24'd0, o_cmd_edges[7:0]}, 32'd9);
    chk("busy_ch0_wait",  {31'd0, o_busy[0]}, 32'd1);
    chk("ctlr_drive_ch0", ctlr_seen[0], 32'd36);
    chk("cons_quiet_cmd", cons_seen[0], 32'd0);

    // controller response 100 cycles later: 33 pulses (3 low / 3 high)
    repeat (100) step();
    for (int p = 0; p < 33; p++) begin
      i_ctlr_rx[0] = 1'b0; repeat (3) step();
      i_ctlr_rx[0] = 1'b1; last_rise = cyc; repeat (3) step();
    end
    run_to(last_rise + 201);
    chk("done_early_ch0", {31'd0, o_done[0]}, 32'd0);
    chk("busy_pre_done",  {31'd0, o_busy[0]}, 32'd1);
    step();
    chk("done_pulse_ch0", {31'd0, o_done[0]}, 32'd1);
    chk("busy_after_done", {31'd0, o_busy[0]}, 32'd0);
    step();
    chk("done_one_cycle", {31'd0, o_done[0]}, 32'd0);
    chk("cons_drive_ch0", cons_seen[0], 32'd99);
    chk("done_cnt_ch0",   done_cnt[0], 32'd1);
    chk("no_timeout_ch0", to_cnt[0], 32'd0);

    // ch0 and ch1 concurrently, ch1 muted; mute flipped on both mid-response
    i_mute = 4'b0010;
    for (int p = 0; p < 5; p++) begin
      i_cons_rx[1:0] = 2'b00; repeat (4) step();
      i_cons_rx[1:0] = 2'b11; last_rise = cyc; repeat (4) step();
    end
    run_to(last_rise + 302);
    mute_exp = 4'b0010;
    for (int p = 0; p < 5; p++) begin
      if (p == 2) i_mute = 4'b0001;
      i_ctlr_rx[1:0] = 2'b00; repeat (3) step();
      i_ctlr_rx[1:0] = 2'b11; last_rise = cyc; repeat (3) step();
    end
    run_to(last_rise + 202);
    chk("done_pair",       {30'd0, o_done[1:0]}, 32'd3);
    chk("cons_drive_ch0b", cons_seen[0], 32'd114);
    chk("muted_ch1",       cons_seen[1], 32'd0);
    chk("ctlr_drive_ch1",  ctlr_seen[1], 32'd20);
    chk("cmd_edges_ch1",   {24'd0, o_cmd_edges[15:8]}, 32'd5);
    chk("cmd_edges_ch0b",  {24'd0, o_cmd_edges[7:0]}, 32'd5);
    i_mute = 4'h0;
    step();
    mute_exp = 4'h0;

    // ch1 with no response; controller line echoes low during the command
    mon_cons[1] = 1'b0;
    i_cons_rx[1] = 1'b0; i_ctlr_rx[1] = 1'b0; repeat (4) step();
    i_cons_rx[1] = 1'b1; repeat (6) step();
    i_ctlr_rx[1] = 1'b1; repeat (4) step();
    i_cons_rx[1] = 1'b0; repeat (4) step();
    i_cons_rx[1] = 1'b1; last_rise = cyc;
    run_to(last_rise + 5201);
    chk("timeout_early", {31'd0, o_timeout[1]}, 32'd0);
    chk("busy_in_wait",  {31'd0, o_busy[1]}, 32'd1);
    step();
    chk("timeout_pulse", {31'd0, o_timeout[1]}, 32'd1);
    chk("busy_after_to", {31'd0, o_busy[1]}, 32'd0);
    step();
    chk("timeout_one_cycle", {31'd0, o_timeout[1]}, 32'd0);
    chk("no_cons_drive_to",  cons_seen[1], 32'd0);
    chk("to_cnt_ch1",        to_cnt[1], 32'd1);
    chk("done_cnt_ch1",      done_cnt[1], 32'd1);
    mon_cons[1] = 1'b1;

    // ch2: reset mid command with the console line held low
    mon_ctlr[2] = 1'b0;
    i_cons_rx[2] = 1'b0; repeat (10) step();
    chk("ctlr_drive_ch2", {31'd0, o_ctlr_oe[2]}, 32'd1);
    chk("busy_ch2",       {31'd0, o_busy[2]}, 32'd1);
    i_rst = 1'b1;
    #1;
    chk("async_rst_ctlr_oe", {28'd0, o_ctlr_oe}, 32'd0);
    chk("async_rst_busy",    {28'd0, o_busy}, 32'd0);
    chk("async_rst_edges",   o_cmd_edges, 32'd0);
    step(); step();
    i_rst = 1'b0;
    repeat (20) step();
    chk("held_low_idle", {31'd0, o_busy[2]}, 32'd0);
    chk("held_low_oe",   {31'd0, o_ctlr_oe[2]}, 32'd0);
    i_cons_rx[2] = 1'b1; repeat (5) step();
    i_cons_rx[2] = 1'b0; repeat (2) step();
    chk("rearm_lat2", {31'd0, o_ctlr_oe[2]}, 32'd0);
    step();
    chk("rearm_lat3",  {31'd0, o_ctlr_oe[2]}, 32'd1);
    chk("rearm_busy",  {31'd0, o_busy[2]}, 32'd1);
    chk("rearm_edges", {24'd0, o_cmd_edges[23:16]}, 32'd1);
    i_cons_rx[2] = 1'b1; step();
    i_rst = 1'b1; step();
    i_rst = 1'b0; repeat (3) step();

    // ch3: 300 single-cycle pulses, edge count saturates
    for (int p = 0; p < 100; p++) begin
      i_cons_rx[3] = 1'b0; step();
      i_cons_rx[3] = 1'b1; step();
    end
    step();
    chk("edges_100", {24'd0, o_cmd_edges[31:24]}, 32'd100);
    for (int p = 0; p < 200; p++) begin
      i_cons_rx[3] = 1'b0; step();
      i_cons_rx[3] = 1'b1; step();
    end
    step();
    chk("edges_sat",      {24'd0, o_cmd_edges[31:24]}, 32'd255);
    chk("ctlr_drive_ch3", ctlr_seen[3], 32'd300);

    chk("mirror_errors", mirr_err, 32'd0);
    chk("both_oe",       both_err, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
